// File: rtl/riscv_dbg_pkg.sv
// Shared debug-path definitions: register-dump FSM states and the default
// architectural dimensions, also used by the debug transmitter.
package riscv_dbg_pkg;

  localparam int DBG_XLEN  = 32;
  localparam int DBG_NREGS = 32;

  typedef enum logic [2:0] {
    DUMP_IDLE   = 3'd0,
    DUMP_FREEZE = 3'd1,
    DUMP_LOAD   = 3'd2,
    DUMP_SEND   = 3'd3,
    DUMP_DONE   = 3'd4
  } dump_state_e;

endpackage

// File: rtl/riscv_regfile_dump.sv
// Register-file dump engine: freezes architectural writes, walks a register
// range through a spare read port and streams each word over valid/ready.
module riscv_regfile_dump
  import riscv_dbg_pkg::*;
#(
  parameter  int XLEN      = DBG_XLEN,
  parameter  int NREGS     = DBG_NREGS,
  parameter  int FIRST_REG = 0,
  parameter  int LAST_REG  = 31,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  output logic [AW-1:0]   rd_addr_o,
  input  logic [XLEN-1:0] rd_data_i,
  output logic            freeze_o,
  output logic [XLEN-1:0] data_o,
  output logic [AW-1:0]   idx_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);

  if (!(FIRST_REG >= 0 && FIRST_REG <= LAST_REG && LAST_REG < NREGS)) begin : g_bad_range
    $error("riscv_regfile_dump: need 0 <= FIRST_REG <= LAST_REG < NREGS");
  end

  localparam logic [AW-1:0] FIRST_IDX = AW'(FIRST_REG);
  localparam logic [AW-1:0] LAST_IDX  = AW'(LAST_REG);

  dump_state_e   state;
  logic [AW-1:0] idx;

  // Status outputs decode straight from the state so an asynchronous reset
  // drops freeze_o immediately and releases the core's regfile writes.
  assign freeze_o  = (state == DUMP_FREEZE) || (state == DUMP_LOAD) || (state == DUMP_SEND);
  assign busy_o    = (state != DUMP_IDLE);
  assign done_o    = (state == DUMP_DONE);
  assign rd_addr_o = (state == DUMP_LOAD) ? idx : '0;

  // NOTE: every state element uses non-blocking assignment so all registers
  // update from the same pre-edge values and simulation matches synthesis.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= DUMP_IDLE;
      idx     <= FIRST_IDX;
      data_o  <= '0;
      idx_o   <= '0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
    end else if (abort_i && state != DUMP_IDLE) begin
      // Abort beats a same-cycle handshake: the word in flight is dropped.
      state   <= DUMP_IDLE;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      case (state)
        DUMP_IDLE: begin
          if (start_i) begin
            state <= DUMP_FREEZE;
            idx   <= FIRST_IDX;
          end
        end
        DUMP_FREEZE: begin
          // One idle cycle lets a writeback already in flight retire.
          state <= DUMP_LOAD;
        end
        DUMP_LOAD: begin
          data_o  <= rd_data_i;
          idx_o   <= idx;
          last_o  <= (idx == LAST_IDX);
          valid_o <= 1'b1;
          state   <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= DUMP_DONE;
            end else begin
              idx   <= idx + AW'(1);
              state <= DUMP_LOAD;
            end
          end
        end
        DUMP_DONE: begin
          last_o <= 1'b0;
          state  <= DUMP_IDLE;
        end
        default: begin
          state <= DUMP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_regfile_dump.sv
// Directed self-checking bench for riscv_regfile_dump: full dump, backpressure,
// abort, start-while-busy, asynchronous reset mid-dump and a 28..30 subrange.
module tb_riscv_regfile_dump;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start0, abort0, ready0;
  logic [AW-1:0]   rd_addr0, idx0;
  logic [XLEN-1:0] rd_data0, data0;
  logic            freeze0, valid0, last0, busy0, done0;

  logic            start1, abort1, ready1;
  logic [AW-1:0]   rd_addr1, idx1;
  logic [XLEN-1:0] rd_data1, data1;
  logic            freeze1, valid1, last1, busy1, done1;

  logic [XLEN-1:0] rf [32];

  assign rd_data0 = rf[rd_addr0];
  assign rd_data1 = rf[rd_addr1];

  riscv_regfile_dump dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .abort_i(abort0),
    .rd_addr_o(rd_addr0), .rd_data_i(rd_data0), .freeze_o(freeze0),
    .data_o(data0), .idx_o(idx0), .valid_o(valid0), .ready_i(ready0),
    .last_o(last0), .busy_o(busy0), .done_o(done0)
  );

  riscv_regfile_dump #(.FIRST_REG(28), .LAST_REG(30)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort1),
    .rd_addr_o(rd_addr1), .rd_data_i(rd_data1), .freeze_o(freeze1),
    .data_o(data1), .idx_o(idx1), .valid_o(valid1), .ready_i(ready1),
    .last_o(last1), .busy_o(busy1), .done_o(done1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a dump on dut0 and follow it to done_o, checking every accepted word.
  task automatic dump_and_check(input bit backpressure, input bit poke_start);
    logic [3:0]      pat;
    int              n, acc_cyc, done_cyc;
    bit              stalled, rdy;
    logic [XLEN-1:0] held_data;
    logic [AW-1:0]   held_idx;
    pat = 4'b1001;
    n = 0; acc_cyc = -10; done_cyc = -1; stalled = 1'b0;
    held_data = '0; held_idx = '0;
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("freeze_state_freeze", freeze0, 1'b1);
    check("freeze_state_valid", valid0, 1'b0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (done0) begin
        done_cyc = cyc;
        break;
      end
      check("freeze_held", freeze0, 1'b1);
      if (stalled) begin
        check("stall_data_stable", data0, held_data);
        check("stall_idx_stable", idx0, held_idx);
      end
      rdy = backpressure ? pat[cyc % 4] : 1'b1;
      ready0 = rdy;
      start0 = poke_start && (cyc == 10);
      if (valid0) begin
        if (rdy) begin
          check("word_idx", idx0, n);
          check("word_data", data0, rf[n]);
          check("word_last", last0, (n == 31));
          acc_cyc = cyc;
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_data = data0;
          held_idx = idx0;
        end
      end
    end
    start0 = 1'b0;
    check("word_count", n, 32);
    check("done_after_last", done_cyc, acc_cyc + 1);
    check("done_freeze_low", freeze0, 1'b0);
    check("done_valid_low", valid0, 1'b0);
    tick();
    check("idle_after_done_busy", busy0, 1'b0);
    check("idle_after_done_pulse", done0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stays_idle", busy0, 1'b0);
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1]  = 32'h1111_1111;
    rf[2]  = 32'h2222_2222;
    rf[29] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0;

    #3;
    check("rst_valid", valid0, 1'b0);
    check("rst_freeze", freeze0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_data", data0, 0);
    check("rst_idx", idx0, 0);
    check("rst_rd_addr", rd_addr0, 0);
    #20;
    rst_n = 1'b1;
    tick();

    // Full dump with ready held high, then with a 1-0-0-1 ready pattern.
    dump_and_check(1'b0, 1'b0);
    dump_and_check(1'b1, 1'b0);

    // Abort in SEND at idx 5, with ready high in the same cycle.
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (valid0 && idx0 == 5) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_idx5", found, 1'b1);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("abort_busy", busy0, 1'b0);
    check("abort_valid", valid0, 1'b0);
    check("abort_freeze", freeze0, 1'b0);
    check("abort_last", last0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", done0, 1'b0);
      tick();
    end

    // Restart after abort (from idx 0) with a stray start pulse mid-dump.
    dump_and_check(1'b0, 1'b1);

    // Asynchronous reset between clock edges while idx 10 is on offer.
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (valid0 && idx0 == 10) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_reached_idx10", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid0, 1'b0);
    check("arst_freeze", freeze0, 1'b0);
    check("arst_busy", busy0, 1'b0);
    check("arst_done", done0, 1'b0);
    check("arst_last", last0, 1'b0);
    check("arst_data", data0, 0);
    check("arst_idx", idx0, 0);
    #13;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_arst_busy", busy0, 1'b0);
    check("post_arst_valid", valid0, 1'b0);
    check("post_arst_done", done0, 1'b0);

    // Subrange instance: registers 28..30, ready held high.
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("sub_freeze", freeze1, 1'b1);
    check("sub_freeze_valid", valid1, 1'b0);
    tick();
    check("sub_load28_addr", rd_addr1, 28);
    check("sub_load28_valid", valid1, 1'b0);
    tick();
    check("sub_w0_valid", valid1, 1'b1);
    check("sub_w0_idx", idx1, 28);
    check("sub_w0_data", data1, 32'h0);
    check("sub_w0_last", last1, 1'b0);
    tick();
    check("sub_load29_addr", rd_addr1, 29);
    check("sub_load29_valid", valid1, 1'b0);
    tick();
    check("sub_w1_idx", idx1, 29);
    check("sub_w1_data", data1, 32'hDEAD_BEEF);
    check("sub_w1_last", last1, 1'b0);
    tick();
    tick();
    check("sub_w2_valid", valid1, 1'b1);
    check("sub_w2_idx", idx1, 30);
    check("sub_w2_last", last1, 1'b1);
    tick();
    check("sub_done", done1, 1'b1);
    check("sub_done_valid", valid1, 1'b0);
    check("sub_done_freeze", freeze1, 1'b0);
    check("sub_done_busy", busy1, 1'b1);
    tick();
    check("sub_idle_busy", busy1, 1'b0);
    check("sub_idle_done", done1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
